// File: rtl/noc_pkg.sv
// Shared definitions for the processing unit: FSM state encoding and the
// default parameter values used by the top and the receive checker.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } pu_state_e;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_N_DEST        = 4;
  localparam int DEF_GRANT_TIMEOUT = 64;

endpackage

// File: rtl/pu_rx_checker.sv
// Receive-side sequence checker: expects payloads 1,2,3,... within each packet,
// restarts at 1 after every tlast beat and counts completed packets.
module pu_rx_checker
  import noc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W:0]   rx_data,
  output logic [15:0]       rx_pkt_count,
  output logic              rx_error
);

  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] payload;
  logic              tlast;

  assign payload = rx_data[DATA_W-1:0];
  assign tlast   = rx_data[DATA_W];

  // Expected value tracks the received payload, so one bad beat flags once
  // and the checker resynchronises on the following beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q        <= DATA_W'(1);
      rx_pkt_count <= 16'd0;
      rx_error     <= 1'b0;
    end else if (rx_valid) begin
      if (payload != exp_q) begin
        rx_error <= 1'b1;
      end
      if (tlast) begin
        exp_q <= DATA_W'(1);
        if (rx_pkt_count != 16'hFFFF) begin
          rx_pkt_count <= rx_pkt_count + 16'd1;
        end
      end else begin
        exp_q <= payload + 1'b1;
      end
    end
  end

endmodule

// File: rtl/processing_unit_gen.sv
// Burst-generating processing unit: requests a destination from the master,
// sends a counting burst of len beats, drains, and checks the receive stream.
module processing_unit_gen
  import noc_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N_DEST        = DEF_N_DEST,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int DEST_W        = $clog2(N_DEST)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tb_request,
  input  logic [DEST_W-1:0] tb_processor,
  input  logic [DATA_W-1:0] tb_len,
  input  logic              master_response,
  input  logic              rx_valid,
  input  logic [DATA_W:0]   data_from_router,
  output logic              request_transfer,
  output logic [DEST_W-1:0] which_processor,
  output logic              processor_ready,
  output logic              tx_valid,
  output logic [DATA_W:0]   data_to_router,
  output logic              req_timeout,
  output logic [15:0]       rx_pkt_count,
  output logic              rx_error
);

  localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GRANT_TIMEOUT - 1);

  pu_state_e         state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              drain_q, drain_d;

  logic              ready_d, req_d, tx_d, timeout_d;
  logic [DEST_W-1:0] which_d;
  logic [DATA_W:0]   data_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      wait_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    pay_d   = pay_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (tb_request) begin
          state_d = ST_REQ;
          dest_d  = tb_processor;
          len_d   = (tb_len == '0) ? DATA_W'(1) : tb_len;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        // A grant arriving on the timeout cycle still wins.
        if (master_response) begin
          state_d = ST_SEND;
          pay_d   = DATA_W'(1);
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (pay_q == len_q) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          pay_d = pay_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and carry no combinational path from inputs.
  always_comb begin
    ready_d   = (state_d == ST_IDLE);
    req_d     = (state_d == ST_REQ);
    tx_d      = (state_d == ST_SEND);
    which_d   = (state_d == ST_REQ) ? dest_d : which_processor;
    data_d    = tx_d ? {(pay_d == len_d), pay_d} : '0;
    timeout_d = (state_q == ST_REQ) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      processor_ready  <= 1'b1;
      request_transfer <= 1'b0;
      which_processor  <= '0;
      tx_valid         <= 1'b0;
      data_to_router   <= '0;
      req_timeout      <= 1'b0;
    end else begin
      processor_ready  <= ready_d;
      request_transfer <= req_d;
      which_processor  <= which_d;
      tx_valid         <= tx_d;
      data_to_router   <= data_d;
      req_timeout      <= timeout_d;
    end
  end

  pu_rx_checker #(
    .DATA_W (DATA_W)
  ) u_rx_checker (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (data_from_router),
    .rx_pkt_count (rx_pkt_count),
    .rx_error     (rx_error)
  );

endmodule

// File: tb/tb_processing_unit_gen.sv
// Directed bench for processing_unit_gen: burst timing, len edge cases,
// grant timeout, receive checker via loopback, and mid-burst reset.
module tb_processing_unit_gen;

  localparam int DATA_W = 8;
  localparam int N_DEST = 4;
  localparam int DEST_W = 2;
  localparam int GRANT_TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              tb_request = 1'b0;
  logic [DEST_W-1:0] tb_processor = '0;
  logic [DATA_W-1:0] tb_len = '0;
  logic              master_response = 1'b0;
  logic              loop_en = 1'b0;
  logic              drv_rx_valid = 1'b0;
  logic [DATA_W:0]   drv_rx_data = '0;
  logic              rx_valid;
  logic [DATA_W:0]   data_from_router;
  logic              request_transfer;
  logic [DEST_W-1:0] which_processor;
  logic              processor_ready;
  logic              tx_valid;
  logic [DATA_W:0]   data_to_router;
  logic              req_timeout;
  logic [15:0]       rx_pkt_count;
  logic              rx_error;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx_valid         = loop_en ? tx_valid : drv_rx_valid;
  assign data_from_router = loop_en ? data_to_router : drv_rx_data;

  processing_unit_gen #(
    .DATA_W(DATA_W), .N_DEST(N_DEST), .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .tb_request(tb_request),
    .tb_processor(tb_processor), .tb_len(tb_len),
    .master_response(master_response), .rx_valid(rx_valid),
    .data_from_router(data_from_router), .request_transfer(request_transfer),
    .which_processor(which_processor), .processor_ready(processor_ready),
    .tx_valid(tx_valid), .data_to_router(data_to_router),
    .req_timeout(req_timeout), .rx_pkt_count(rx_pkt_count), .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues a request, grants after grant_delay cycles; returns with beat 1 visible.
  task automatic do_request(input logic [DEST_W-1:0] dest, input logic [DATA_W-1:0] len,
                            input int grant_delay);
    tb_processor = dest;
    tb_len       = len;
    tb_request   = 1'b1;
    tick();
    tb_request = 1'b0;
    repeat (grant_delay - 1) tick();
    master_response = 1'b1;
    tick();
    master_response = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({processor_ready, request_transfer, which_processor, tx_valid, data_to_router,
         req_timeout, rx_pkt_count, rx_error} !== {1'b1, 1'b0, 2'd0, 1'b0, 9'h000, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b req=%b which=%0d tx=%b data=%h to=%b cnt=%0d err=%b, required 1 0 0 0 000 0 0 0",
               processor_ready, request_transfer, which_processor, tx_valid, data_to_router,
               req_timeout, rx_pkt_count, rx_error);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (processor_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b required 1", processor_ready);
    end
  endtask

  task automatic test_basic_burst();
    logic [DATA_W:0] exp_beats [3];
    exp_beats[0] = 9'h001; exp_beats[1] = 9'h002; exp_beats[2] = 9'h103;
    tb_processor = 2'd2; tb_len = 8'd3; tb_request = 1'b1;
    tick();
    tb_request = 1'b0;
    n_checks++;
    if ({request_transfer, which_processor, processor_ready} !== {1'b1, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_req: req=%b which=%0d ready=%b required 1 2 0",
               request_transfer, which_processor, processor_ready);
    end
    master_response = 1'b1;
    tick();
    master_response = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_valid, data_to_router, request_transfer} !== {1'b1, exp_beats[i], 1'b0}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: tx=%b data=%h req=%b required 1 %h 0",
                 i, tx_valid, data_to_router, request_transfer, exp_beats[i]);
      end
      tb_request = (i == 1);
      tb_processor = 2'd1;
      tick();
      tb_request = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({tx_valid, data_to_router, processor_ready, which_processor} !== {1'b0, 9'h000, 1'b0, 2'd2}) begin
        n_fail++;
        $display("FAIL basic_drain%0d: tx=%b data=%h ready=%b which=%0d required 0 000 0 2",
                 i, tx_valid, data_to_router, processor_ready, which_processor);
      end
      tick();
    end
    n_checks++;
    if ({processor_ready, request_transfer} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_idle: ready=%b req=%b required 1 0", processor_ready, request_transfer);
    end
  endtask

  task automatic test_len_zero();
    master_response = 1'b1;
    tick();
    master_response = 1'b0;
    n_checks++;
    if ({processor_ready, tx_valid, request_transfer} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_grant_ignored: ready=%b tx=%b req=%b required 1 0 0",
               processor_ready, tx_valid, request_transfer);
    end
    do_request(2'd3, 8'd0, 3);
    n_checks++;
    if ({tx_valid, data_to_router} !== {1'b1, 9'h101}) begin
      n_fail++;
      $display("FAIL len0_beat: tx=%b data=%h required 1 101", tx_valid, data_to_router);
    end
    tick();
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_single: tx=%b required 0", tx_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    tb_processor = 2'd1; tb_len = 8'd4; tb_request = 1'b1;
    tick();
    tb_request = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ({request_transfer, req_timeout} !== 2'b10) bad++;
      tick();
    end
    if ({request_transfer, req_timeout} !== 2'b10) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_wait: %0d of 8 REQ cycles wrong, required 0", bad);
    end
    tick();
    n_checks++;
    if ({req_timeout, request_transfer, processor_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL timeout_pulse: to=%b req=%b ready=%b required 1 0 1",
               req_timeout, request_transfer, processor_ready);
    end
    tick();
    n_checks++;
    if (req_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_one_cycle: to=%b required 0", req_timeout);
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    do_request(2'd0, 8'd3, 2);
    repeat (6) tick();
    do_request(2'd1, 8'd2, 2);
    repeat (5) tick();
    loop_en = 1'b0;
    n_checks++;
    if ({rx_pkt_count, rx_error} !== {16'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL loopback: cnt=%0d err=%b required 2 0", rx_pkt_count, rx_error);
    end
  endtask

  task automatic test_rx_error();
    logic [DATA_W:0] seq [5];
    seq[0] = 9'h001; seq[1] = 9'h002; seq[2] = 9'h003; seq[3] = 9'h005; seq[4] = 9'h101;
    for (int i = 0; i < 5; i++) begin
      drv_rx_valid = 1'b1;
      drv_rx_data  = seq[i];
      tick();
      n_checks++;
      if (rx_error !== (i >= 3)) begin
        n_fail++;
        $display("FAIL rx_error_step%0d: got %b required %b", i, rx_error, (i >= 3));
      end
    end
    drv_rx_valid = 1'b0;
    drv_rx_data  = '0;
    repeat (3) tick();
    n_checks++;
    if ({rx_error, rx_pkt_count} !== {1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL rx_error_sticky: err=%b cnt=%0d required 1 3", rx_error, rx_pkt_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_request(2'd1, 8'd10, 2);
    tick();
    n_checks++;
    if (data_to_router !== 9'h002) begin
      n_fail++;
      $display("FAIL mid_beat2: data=%h required 002", data_to_router);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({processor_ready, request_transfer, which_processor, tx_valid, data_to_router,
         req_timeout, rx_pkt_count, rx_error} !== {1'b1, 1'b0, 2'd0, 1'b0, 9'h000, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: ready=%b req=%b which=%0d tx=%b data=%h to=%b cnt=%0d err=%b, required 1 0 0 0 000 0 0 0",
               processor_ready, request_transfer, which_processor, tx_valid, data_to_router,
               req_timeout, rx_pkt_count, rx_error);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_partial: tx=%b required 0", tx_valid);
    end
    do_request(2'd2, 8'd2, 2);
    n_checks++;
    if (data_to_router !== 9'h001) begin
      n_fail++;
      $display("FAIL mid_restart_beat1: data=%h required 001", data_to_router);
    end
    tick();
    n_checks++;
    if (data_to_router !== 9'h102) begin
      n_fail++;
      $display("FAIL mid_restart_beat2: data=%h required 102", data_to_router);
    end
    repeat (3) tick();
  endtask

  task automatic test_max_len();
    int bad = 0;
    logic [DATA_W:0] exp_d;
    logic [DATA_W:0] last_d = '0;
    do_request(2'd3, 8'd255, 2);
    for (int i = 1; i <= 255; i++) begin
      exp_d = {(i == 255), 8'(i)};
      if (!(tx_valid === 1'b1 && data_to_router === exp_d)) bad++;
      last_d = data_to_router;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL maxlen_beats: %0d wrong beats, required 0", bad);
    end
    n_checks++;
    if ({last_d, tx_valid} !== {9'h1FF, 1'b0}) begin
      n_fail++;
      $display("FAIL maxlen_last: last=%h tx_after=%b required 1ff 0", last_d, tx_valid);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_len_zero();
    test_timeout();
    test_loopback();
    test_rx_error();
    test_reset_mid_burst();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/processing_unit_gen.md
PROCESSING_UNIT_GEN -- requirements
Module: processing_unit_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload width; legal range 4..16.
REQ-002 Parameter N_DEST, default 4, number of destination processors; legal range 2..16; DEST_W = clog2(N_DEST).
REQ-003 Parameter GRANT_TIMEOUT, default 64, maximum cycles spent waiting for grant before abort.
REQ-004 Ports (name, direction, width, meaning):
- clock in 1: single clock; all logic on rising edge.
- reset in 1: asynchronous, active-high.
- tb_request in 1: user request to start a burst.
- tb_processor in DEST_W: user destination.
- tb_len in DATA_W: user burst length.
- master_response in 1: grant from master.
- rx_valid in 1: data_from_router beat valid.
- data_from_router in DATA_W+1: {tlast, payload}.
- request_transfer out 1: request to master.
- which_processor out DEST_W: requested destination.
- processor_ready out 1: block is idle and accepts tb_request.
- tx_valid out 1: data_to_router beat valid.
- data_to_router out DATA_W+1: {tlast, payload}.
- req_timeout out 1: one-cycle pulse on grant timeout.
- rx_pkt_count out 16: received packets.
- rx_error out 1: sticky sequence error.

Function
REQ-005 FSM states: IDLE, REQ, SEND, DRAIN; all outputs registered.
REQ-006 IDLE: processor_ready=1; if tb_request=1, capture tb_processor and tb_len (tb_len=0 captured as 1), go to REQ.
REQ-007 REQ: request_transfer=1, which_processor=captured destination; on master_response=1, go to SEND next cycle, with request_transfer=0 in that cycle.
REQ-008 REQ: wait counter counts cycles; when it reaches GRANT_TIMEOUT with no grant, pulse req_timeout for 1 cycle, go to IDLE, drop request.
REQ-009 Grant and timeout in the same cycle: grant wins.
REQ-010 SEND: one beat per cycle, tx_valid=1; payload counter starts at 1 and increments to captured len; tlast=1 only on the beat where payload==len. A burst is exactly len beats, no gaps.
REQ-011 After the tlast beat go to DRAIN for exactly 2 cycles with tx_valid=0, then IDLE.
REQ-012 processor_ready=0 in REQ, SEND and DRAIN; tb_request ignored outside IDLE.
REQ-013 master_response outside REQ is ignored.
REQ-014 When tx_valid=0, data_to_router=0 and which_processor holds its last value.
REQ-015 Receive checker (independent of FSM): expected value starts at 1; on rx_valid, if payload != expected, set rx_error (sticky until reset).
REQ-016 Checker expected value: next = payload+1 after a non-tlast beat; on a tlast beat, reset expected to 1 and increment rx_pkt_count, saturating at 0xFFFF.
REQ-017 Payload arithmetic is modulo 2^DATA_W; len = 2^DATA_W-1 is legal and produces no wrap.

Reset
REQ-018 Reset asserted: state=IDLE and all counters cleared.
REQ-019 Output reset values: processor_ready=1, request_transfer=0, which_processor=0, tx_valid=0, data_to_router=0, req_timeout=0, rx_pkt_count=0, rx_error=0.
REQ-020 Reset mid-burst aborts immediately; no partial tlast is emitted after release.

Structure
REQ-021 FSM state enum and default parameter constants live in shared package noc_pkg.
REQ-022 The receive checker is sub-module pu_rx_checker, instantiated once.

Verification
REQ-023 DATA_W=8: tb_processor=2, tb_len=3, grant 2 cycles after request -> which_processor=2; beats 0x001, 0x002, 0x103; 2 idle cycles; then processor_ready=1.
REQ-024 tb_len=0 -> single beat 0x101.
REQ-025 No grant, GRANT_TIMEOUT=8 -> req_timeout pulses after 8 REQ cycles; request_transfer=0; processor_ready=1.
REQ-026 Loop data_to_router into data_from_router for 2 bursts -> rx_pkt_count=2, rx_error=0; inject payload 5 where 4 expected -> rx_error=1 and stays 1.
REQ-027 Reset at beat 2 of a 10-beat burst -> all outputs take reset values immediately; next burst starts at payload 1.
REQ-028 tb_len=255 -> 255 beats, last beat 0x1FF, no wrap to 0.
